harmonica_voice: RTL

Single-voice tone generator for the harmonica datapath, directly downstream of the 8 kHz sample clock divider. It turns every transition of the divider's output into one audio sample tick. On each tick it advances a phase accumulator for the selected key, steps an attack/sustain/release envelope, and emits one 8-bit unsigned sample with a one-cycle valid strobe for the PWM/DAC stage.

---
 rtl/harmonica_voice.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/harmonica_voice.sv
// harmonica_voice: single-voice tone generator with an ASR envelope; each tick_clk edge yields one sample. Optional HARMONICA_TRIANGLE_EN selects a triangle wave.
// Latency: tick edge to sample_valid is 2 clk_in cycles; keys pass a 2-flop synchronizer, so they are seen 2 cycles late.
// Backpressure: none; sample_valid is a one-cycle strobe that the downstream stage must take when offered.
module harmonica_voice #(
    parameter int unsigned ATTACK_STEP  = 4,
    parameter int unsigned RELEASE_STEP = 2
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_clk,
    input  logic [7:0] key,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    output logic       active
);

    typedef enum logic [1:0] {ST_IDLE, ST_ATTACK, ST_SUSTAIN, ST_RELEASE} state_t;

    localparam logic [8:0] ATT_STEP9 = 9'(ATTACK_STEP);
    localparam logic [7:0] REL_STEP8 = 8'(RELEASE_STEP);

    state_t      state_q, state_d;
    logic [7:0]  key_s1_q, key_s2_q;
    logic        tick_q, primed_q, tick_d1_q;
    logic [7:0]  env_q, env_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] inc_q, inc_d;
    logic [7:0]  sample_out_q, sample_out_d;
    logic        sample_valid_q;

    logic        tick, key_any, do_attack, do_release;
    logic [15:0] sel_inc;
    logic [8:0]  env_add;
    logic [7:0]  env_att, env_rel, wave;
    logic [15:0] prod;

    function automatic logic [15:0] inc_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    inc_lut = 16'd2143;
            3'd1:    inc_lut = 16'd2406;
            3'd2:    inc_lut = 16'd2700;
            3'd3:    inc_lut = 16'd2861;
            3'd4:    inc_lut = 16'd3211;
            3'd5:    inc_lut = 16'd3604;
            3'd6:    inc_lut = 16'd4046;
            default: inc_lut = 16'd4286;
        endcase
    endfunction

    // primed masks the bogus edge seen when tick_q reloads after reset
    assign tick = primed_q & (tick_clk ^ tick_q);

    // lowest pressed key wins; with no key the current increment is kept
    always_comb begin
        key_any = |key_s2_q;
        sel_inc = inc_q;
        for (int i = 7; i >= 0; i--) begin
            if (key_s2_q[i]) sel_inc = inc_lut(3'(i));
        end
    end

    assign env_add = {1'b0, env_q} + ATT_STEP9;
    assign env_att = env_add[8] ? 8'hFF : env_add[7:0];
    assign env_rel = (env_q > REL_STEP8) ? (env_q - REL_STEP8) : 8'd0;

    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        phase_d    = phase_q;
        inc_d      = inc_q;
        do_attack  = 1'b0;
        do_release = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE:    do_attack = key_any;
                ST_ATTACK:  if (key_any) do_attack = 1'b1; else state_d = ST_RELEASE;
                ST_SUSTAIN: do_release = !key_any;
                ST_RELEASE: if (key_any) do_attack = 1'b1; else do_release = 1'b1;
                default:    state_d = ST_IDLE;
            endcase
        end
        if (do_attack) begin
            env_d   = env_att;
            state_d = (env_att == 8'hFF) ? ST_SUSTAIN : ST_ATTACK;
        end
        if (do_release) begin
            env_d   = env_rel;
            state_d = (env_rel == 8'd0) ? ST_IDLE : ST_RELEASE;
        end
        // legato: key changes reload the increment but never reset phase
        if (tick) begin
            if (state_d != ST_IDLE) begin
                inc_d   = sel_inc;
                phase_d = phase_q + sel_inc;
            end else begin
                phase_d = 16'd0;
            end
        end
    end

`ifdef HARMONICA_TRIANGLE_EN
    assign wave = phase_q[15] ? ~phase_q[14:7] : phase_q[14:7];
`else
    assign wave = phase_q[15] ? 8'd255 : 8'd0;
`endif

    assign prod         = 16'(wave) * 16'(env_q);
    assign sample_out_d = tick_d1_q ? prod[15:8] : sample_out_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q       <= 8'd0;
            key_s2_q       <= 8'd0;
            tick_q         <= 1'b0;
            primed_q       <= 1'b0;
            tick_d1_q      <= 1'b0;
            state_q        <= ST_IDLE;
            env_q          <= 8'd0;
            phase_q        <= 16'd0;
            inc_q          <= 16'd0;
            sample_out_q   <= 8'd0;
            sample_valid_q <= 1'b0;
        end else begin
            key_s1_q       <= key;
            key_s2_q       <= key_s1_q;
            tick_q         <= tick_clk;
            primed_q       <= 1'b1;
            tick_d1_q      <= tick;
            state_q        <= state_d;
            env_q          <= env_d;
            phase_q        <= phase_d;
            inc_q          <= inc_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= tick_d1_q;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign active       = (state_q != ST_IDLE);

endmodule
